timer_core_logic: RTL and testbench

TIMER_CORE_LOGIC -- requirements
Module: timer_core_logic

---
 rtl/timer_pkg.sv | 28 ++
 rtl/tick_gen.sv | 54 +++++
 rtl/timer_core_logic.sv | 215 +++++++++++++++++++++
 tb/tb_timer_core_logic.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the kitchen-timer / stopwatch core:
//   - timer_state_e : control FSM states
//   - SEC_MAX       : last value of the seconds field
//   - field widths and the default prescaler ratio
//   - preset_minutes: converts the 3-bit TimeControl code to a minute count
// -----------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_e;

    localparam int SEC_MAX              = 59;
    localparam int CLKS_PER_SEC_DEFAULT = 1;
    localparam int SEC_W                = 6;
    localparam int MIN_W                = 4;

    // TimeControl encodes minutes-minus-one, so 3'b000 means one minute.
    function automatic logic [MIN_W-1:0] preset_minutes(input logic [2:0] tc);
        return {1'b0, tc} + 4'd1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// One-second prescaler. Counts 0..CLKS_PER_SEC-1 while enabled, holds its
// value while disabled, and returns to zero on clear.
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-high reset
//   enable - advance the prescaler this cycle
//   clear  - synchronous return to zero (has priority over enable)
//   tick   - high on the enabled cycle in which the count wraps
// -----------------------------------------------------------------------------
module tick_gen
    import timer_pkg::*;
#(
    parameter int CLKS_PER_SEC = CLKS_PER_SEC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             wrap_s;

    assign wrap_s = (cnt_r == CNT_LAST);

    // The tick must coincide with the wrapping cycle so the time counters
    // advance in the same clock as the prescaler rolls over; hence the
    // output is decoded from the count rather than registered again.
    assign tick = enable & wrap_s;

    // Prescaler count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (enable) begin
            if (wrap_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/timer_core_logic.sv
// -----------------------------------------------------------------------------
// timer_core_logic
// Countdown timer / count-up stopwatch with a single start/stop pushbutton.
// Ports:
//   clk          - system clock, all state changes on the rising edge
//   rst          - asynchronous active-high reset
//   StartStop    - pushbutton, active-low (0 = pressed), asynchronous
//   ModeSel      - 0 = countdown timer, 1 = count-up stopwatch
//   TimeControl  - preset minutes minus one (000 = 1 min ... 111 = 8 min)
//   LSBbinaryout - seconds field, binary 0..59 (upper bits zero)
//   MSBbinaryout - minutes field, binary 0..8  (upper bits zero)
//   StopLED      - 1 whenever the count is not advancing
// -----------------------------------------------------------------------------
module timer_core_logic
    import timer_pkg::*;
#(
    parameter int CLKS_PER_SEC = CLKS_PER_SEC_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       StartStop,
    input  logic       ModeSel,
    input  logic [2:0] TimeControl,
    output logic [7:0] LSBbinaryout,
    output logic [7:0] MSBbinaryout,
    output logic       StopLED
);

    // ---------------------------------------------------------------------
    // Pushbutton synchronizer and press detector
    // ---------------------------------------------------------------------
    logic ss_meta_r;
    logic ss_sync_r;
    logic ss_prev_r;
    logic press_s;

    // The flops clear to 0 (the "pressed" level) so that a button already
    // held down across reset release cannot look like a fresh 1->0 edge;
    // the button must first be seen released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_meta_r <= 1'b0;
            ss_sync_r <= 1'b0;
            ss_prev_r <= 1'b0;
        end else begin
            ss_meta_r <= StartStop;
            ss_sync_r <= ss_meta_r;
            ss_prev_r <= ss_sync_r;
        end
    end

    // One-cycle pulse on the released->pressed transition only.
    assign press_s = ss_prev_r & ~ss_sync_r;

    // ---------------------------------------------------------------------
    // Control FSM, time counters and prescaler hookup
    // ---------------------------------------------------------------------
    timer_state_e     state_r;
    timer_state_e     state_nxt_s;
    logic             start_s;
    logic             tick_s;
    logic             run_s;

    logic             mode_r;
    logic [MIN_W-1:0] limit_min_r;
    logic [MIN_W-1:0] min_r;
    logic [SEC_W-1:0] sec_r;

    logic [MIN_W-1:0] min_nxt_s;
    logic [SEC_W-1:0] sec_nxt_s;
    logic             limit_hit_s;

    logic [MIN_W-1:0] preset_min_s;
    logic [MIN_W-1:0] idle_min_s;
    logic [MIN_W-1:0] min_disp_s;
    logic [SEC_W-1:0] sec_disp_s;

    logic             stop_led_r;

    assign run_s        = (state_r == RUN);
    assign preset_min_s = preset_minutes(TimeControl);
    assign idle_min_s   = ModeSel ? 4'd0 : preset_min_s;

    tick_gen #(
        .CLKS_PER_SEC (CLKS_PER_SEC)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (run_s),
        .clear  (start_s),
        .tick   (tick_s)
    );

    // Next time value for one tick, plus detection of the end-of-count value.
    // Both directions saturate at their end point so a field can never leave
    // its legal range even if a tick were to arrive there.
    always_comb begin
        min_nxt_s   = min_r;
        sec_nxt_s   = sec_r;
        limit_hit_s = 1'b0;
        if (mode_r == 1'b0) begin
            if ((min_r == 4'd0) && (sec_r == 6'd0)) begin
                min_nxt_s = min_r;
                sec_nxt_s = sec_r;
            end else if (sec_r == 6'd0) begin
                sec_nxt_s = 6'(SEC_MAX);
                min_nxt_s = min_r - 4'd1;
            end else begin
                sec_nxt_s = sec_r - 6'd1;
            end
            limit_hit_s = (min_nxt_s == 4'd0) && (sec_nxt_s == 6'd0);
        end else begin
            if ((min_r == limit_min_r) && (sec_r == 6'd0)) begin
                min_nxt_s = min_r;
                sec_nxt_s = sec_r;
            end else if (sec_r == 6'(SEC_MAX)) begin
                sec_nxt_s = 6'd0;
                min_nxt_s = min_r + 4'd1;
            end else begin
                sec_nxt_s = sec_r + 6'd1;
            end
            limit_hit_s = (min_nxt_s == limit_min_r) && (sec_nxt_s == 6'd0);
        end
    end

    // FSM next-state decode. In RUN the tick is applied before the press is
    // considered, and reaching the end of count overrides a simultaneous
    // press (DONE wins over PAUSE).
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (press_s) begin
                    state_nxt_s = RUN;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (tick_s && limit_hit_s) begin
                    state_nxt_s = DONE;
                end else if (press_s) begin
                    state_nxt_s = PAUSE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            PAUSE: begin
                if (press_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = PAUSE;
                end
            end
            DONE: begin
                state_nxt_s = DONE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register and the registered stop indicator derived from it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            stop_led_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            stop_led_r <= (state_nxt_s != RUN);
        end
    end

    // Time counters. Mode and limit are captured when leaving IDLE so that
    // later switch changes have no effect until the next reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r      <= 1'b0;
            limit_min_r <= 4'd1;
            min_r       <= 4'd0;
            sec_r       <= 6'd0;
        end else if (start_s) begin
            mode_r      <= ModeSel;
            limit_min_r <= preset_min_s;
            min_r       <= idle_min_s;
            sec_r       <= 6'd0;
        end else if (run_s && tick_s) begin
            min_r       <= min_nxt_s;
            sec_r       <= sec_nxt_s;
        end else begin
            min_r       <= min_r;
            sec_r       <= sec_r;
        end
    end

    // Display selection: IDLE (including while in reset) follows the
    // switches directly; every other state shows the running counters.
    always_comb begin
        if (state_r == IDLE) begin
            min_disp_s = idle_min_s;
            sec_disp_s = 6'd0;
        end else begin
            min_disp_s = min_r;
            sec_disp_s = sec_r;
        end
    end

    assign LSBbinaryout = {2'b00, sec_disp_s};
    assign MSBbinaryout = {4'b0000, min_disp_s};
    assign StopLED      = stop_led_r;

endmodule

// File: tb/tb_timer_core_logic.sv
// -----------------------------------------------------------------------------
// tb_timer_core_logic
// Self-checking bench for timer_core_logic. A reference model tracks the
// time as a plain count of seconds and the control state as a small integer;
// DUT outputs are compared every cycle, #1 after the rising edge.
// -----------------------------------------------------------------------------
module tb_timer_core_logic;

    localparam int N = 1;

    logic       clk;
    logic       rst;
    logic       StartStop;
    logic       ModeSel;
    logic [2:0] TimeControl;
    logic [7:0] LSBbinaryout;
    logic [7:0] MSBbinaryout;
    logic       StopLED;

    int n_checks;
    int n_errors;

    // model: 0 idle, 1 run, 2 pause, 3 done
    int m_state;
    int m_t;
    int m_lim;
    int m_mode;
    int m_pres;
    int m_pipe[$];

    timer_core_logic #(.CLKS_PER_SEC(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .StartStop    (StartStop),
        .ModeSel      (ModeSel),
        .TimeControl  (TimeControl),
        .LSBbinaryout (LSBbinaryout),
        .MSBbinaryout (MSBbinaryout),
        .StopLED      (StopLED)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic void m_reset();
        m_state = 0;
        m_pres  = 0;
        m_pipe  = '{0, 0, 0};
    endfunction

    // One rising edge of the reference model (input values as seen at the edge).
    function automatic void m_edge();
        bit press;
        bit tick;
        bit reached;
        press  = (m_pipe[2] == 1) && (m_pipe[1] == 0);
        m_pipe = '{int'(StartStop), m_pipe[0], m_pipe[1]};
        case (m_state)
            0: if (press) begin
                m_mode  = int'(ModeSel);
                m_lim   = (int'(TimeControl) + 1) * 60;
                m_t     = (m_mode == 1) ? 0 : m_lim;
                m_pres  = 0;
                m_state = 1;
            end
            1: begin
                tick    = (m_pres == N - 1);
                m_pres  = tick ? 0 : m_pres + 1;
                reached = 1'b0;
                if (tick) begin
                    m_t     = (m_mode == 1) ? m_t + 1 : m_t - 1;
                    reached = (m_mode == 1) ? (m_t == m_lim) : (m_t == 0);
                end
                if (reached) m_state = 3;
                else if (press) m_state = 2;
            end
            2: if (press) m_state = 1;
            default: ;
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        int et;
        et = (m_state == 0) ? (ModeSel ? 0 : (int'(TimeControl) + 1) * 60) : m_t;
        check_value({tag, "_sec"}, int'(LSBbinaryout), et % 60);
        check_value({tag, "_min"}, int'(MSBbinaryout), et / 60);
        check_value({tag, "_led"}, int'(StopLED), (m_state == 1) ? 0 : 1);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (!rst) m_edge();
            #1;
            check_outputs("cyc");
        end
    endtask

    task automatic press1();
        StartStop = 1'b0;
        cycles(1);
        StartStop = 1'b1;
        cycles(3);
    endtask

    task automatic do_reset(input logic mode, input logic [2:0] tc);
        ModeSel     = mode;
        TimeControl = tc;
        StartStop   = 1'b1;
        rst         = 1'b1;
        m_reset();
        #1;
        check_outputs("rst");
        cycles(2);
        rst = 1'b0;
        cycles(4);
    endtask

    task automatic expect_time(input string tag, input int mm, input int ss, input int led);
        check_value({tag, "_min"}, int'(MSBbinaryout), mm);
        check_value({tag, "_sec"}, int'(LSBbinaryout), ss);
        check_value({tag, "_led"}, int'(StopLED), led);
    endtask

    initial begin
        int lat;
        n_checks    = 0;
        n_errors    = 0;
        m_t         = 0;
        m_lim       = 60;
        m_mode      = 0;
        rst         = 1'b1;
        StartStop   = 1'b1;
        ModeSel     = 1'b0;
        TimeControl = 3'd1;
        m_reset();

        // Countdown 02:00 to completion, then a press in DONE.
        do_reset(1'b0, 3'd1);
        expect_time("cd_reset", 2, 0, 1);
        StartStop = 1'b0;
        lat = 99;
        for (int i = 1; i <= 6; i++) begin
            cycles(1);
            if (StopLED == 1'b0) begin
                lat = i;
                break;
            end
        end
        check_value("start_latency_le3", (lat <= 3) ? 1 : 0, 1);
        StartStop = 1'b1;
        cycles(120);
        expect_time("cd_done", 0, 0, 1);
        press1();
        cycles(3);
        expect_time("done_press_ignored", 0, 0, 1);

        // Pause at 01:55 and resume.
        do_reset(1'b0, 3'd1);
        press1();
        cycles(1);
        press1();
        expect_time("paused", 1, 55, 1);
        cycles(5);
        expect_time("paused_hold", 1, 55, 1);
        press1();
        expect_time("resumed", 1, 54, 0);

        // Stopwatch up to 03:00.
        do_reset(1'b1, 3'd2);
        press1();
        cycles(58);
        expect_time("sw_0059", 0, 59, 0);
        cycles(1);
        expect_time("sw_0100", 1, 0, 0);
        cycles(120);
        expect_time("sw_limit", 3, 0, 1);
        cycles(5);
        expect_time("sw_hold", 3, 0, 1);

        // Reset mid-run shows the IDLE value at once.
        do_reset(1'b0, 3'd5);
        press1();
        cycles(20);
        TimeControl = 3'd0;
        rst = 1'b1;
        m_reset();
        #1;
        expect_time("midrun_rst", 1, 0, 1);
        cycles(2);
        rst = 1'b0;
        cycles(4);

        // Long hold gives one press; TimeControl change during RUN ignored.
        do_reset(1'b0, 3'd7);
        StartStop = 1'b0;
        cycles(50);
        TimeControl = 3'd0;
        cycles(50);
        StartStop = 1'b1;
        cycles(3);
        expect_time("long_hold", 6, 20, 0);

        // Button held low across reset release produces no press.
        StartStop = 1'b0;
        rst = 1'b1;
        m_reset();
        cycles(2);
        rst = 1'b0;
        cycles(10);
        expect_time("held_at_release", 1, 0, 1);
        StartStop = 1'b1;
        cycles(4);

        // Randomised phase against the model.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 99) < 6) StartStop = ~StartStop;
            if ($urandom_range(0, 99) < 2) ModeSel = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 2) TimeControl = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 999) < 3) begin
                rst = 1'b1;
                m_reset();
                #1;
                check_outputs("rnd_rst");
                cycles(1 + $urandom_range(0, 2));
                rst = 1'b0;
            end
            cycles(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
